mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Downstream neighbour of the execute stage: EXE/MEM pipeline register, word-addressed data memory, MEM/WB pipeline register.
- Consumes the ALU result, the forwarded store operand (`B`), the destination register and the gated write enables produced in EXE.
- Returns `MEM_*` and `WB_*` signals to the execute-stage forwarding/stall logic and to the register file write port.

Parameters:
- ADDR_W, 10, data-memory word-address width (2^ADDR_W 32-bit words).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- EXE_Result  input  32  ALU result; memory byte address for loads and stores.
- EXE_B  input  32  forwarded rt operand; store data.
- EXE_Rw  input  5  destination register number.
- EXE_RegWr  input  1  register write enable (already gated by overflow and stall).
- EXE_MemWr  input  1  memory write enable (already gated by stall).
- EXE_MemtoReg  input  1  load select.
- stall  input  1  load-use stall from EXE; forces a bubble into EXE/MEM.
- MEM_Result  output  32  registered ALU result in MEM (forwarding source).
- MEM_Rw  output  5  destination register in MEM.
- MEM_RegWr  output  1  register write enable in MEM.
- MEM_MemtoReg  output  1  load flag in MEM (used by stall detection).
- MEM_AlignErr  output  1  combinational misaligned-access flag for the instruction currently in MEM.
- WB_Rw  output  5  destination register in WB.
- WB_RegWr  output  1  register file write enable.
- WB_BusW  output  32  register file write data.

Behaviour:
- Reset, synchronous and active-high:
  - clears all EXE/MEM and MEM/WB registers: `MEM_Result`=0, `MEM_Rw`=0, `MEM_RegWr`=0, `MEM_MemtoReg`=0, internal `MEM_MemWr`/`MEM_B`=0, `WB_Rw`=0, `WB_RegWr`=0, `WB_BusW`=0.
  - `MEM_AlignErr` is therefore 0 while reset is held.
  - Reset has priority over `stall`.
  - Memory array is not cleared.
- EXE/MEM register, each rising edge without reset:
  - `stall`=1: load a bubble. `RegWr`=`MemWr`=`MemtoReg`=0, `Rw`=0, `Result`/`B` hold don't-care (implementation: 0).
  - otherwise: capture all `EXE_*` inputs.
  - `EXE_Rw`=0: captured `RegWr` forced to 0, so `$0` is never forwarded or written.
- Latency:
  - `EXE_*` appear on `MEM_*` one cycle later.
  - `WB_*` appear one cycle after that (2 cycles EXE to WB).
  - No backpressure: the stage never stalls itself.
- Memory:
  - Word index = `MEM_Result[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
  - Read is asynchronous, from `MEM_Result`.
  - Write is synchronous, at the rising edge that ends the MEM cycle, when `MEM_MemWr`=1 and the access is aligned.
- Alignment:
  - `MEM_AlignErr` = (`MEM_MemWr` | `MEM_MemtoReg`) & (`MEM_Result[1:0]` != 0).
  - On error, the store is suppressed and the load returns 0.
  - `RegWr` still propagates; exception handling belongs to a later block.
- MEM/WB register, each edge without reset:
  - `WB_Rw` <= `MEM_Rw`; `WB_RegWr` <= `MEM_RegWr`.
  - `WB_BusW` <= `MEM_MemtoReg` ? read data : `MEM_Result`.
- Simultaneous `MEM_MemWr` and `MEM_MemtoReg` (illegal encoding): the write occurs and the load captures the pre-write word.
- Store followed immediately by a load to the same address: the load (next cycle in MEM) sees the new data. No bypass needed.
- Reset asserted mid-stream:
  - in-flight instructions are discarded.
  - a store in MEM at the reset edge is NOT performed; reset masks the write enable.

Test Plan:
- Reset for 2 cycles, then idle -> every `MEM_*`/`WB_*` output = 0 and `MEM_AlignErr`=0.
- ALU op `EXE_Result`=0x0000_0055, `Rw`=8, `RegWr`=1 -> cycle+1: `MEM_Result`=0x55, `MEM_Rw`=8. Cycle+2: `WB_BusW`=0x55, `WB_Rw`=8, `WB_RegWr`=1.
- Store `EXE_Result`=0x10, `B`=0xDEADBEEF, `MemWr`=1, then load `EXE_Result`=0x10, `MemtoReg`=1, `Rw`=9 -> `WB_BusW`=0xDEADBEEF two cycles after the load enters.
- `stall`=1 with `EXE_RegWr`=1, `EXE_MemtoReg`=1, `Rw`=5 -> next cycle `MEM_RegWr`=0, `MEM_MemtoReg`=0, `MEM_Rw`=0. Following cycle `WB_RegWr`=0.
- Store to 0x13 (misaligned) with `B`=0x1234 -> `MEM_AlignErr`=1 for that cycle. A later load from 0x10 returns the prior contents unchanged. A load from 0x22 returns `WB_BusW`=0 with `AlignErr`=1.
- `Rw`=0 with `RegWr`=1, and alias check -> `MEM_RegWr`=0. With ADDR_W=10, a store to 0x1000_0004 and a load from 0x4 return the same word. Reset asserted while a store is in MEM -> that word is unchanged afterwards.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: EXE/MEM register, word-addressed data memory, MEM/WB register.
// Feeds the MEM_* forwarding/stall signals and the register-file write port.
module mem_wb_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] EXE_Result,
  input  logic [31:0] EXE_B,
  input  logic [4:0]  EXE_Rw,
  input  logic        EXE_RegWr,
  input  logic        EXE_MemWr,
  input  logic        EXE_MemtoReg,
  input  logic        stall,
  output logic [31:0] MEM_Result,
  output logic [4:0]  MEM_Rw,
  output logic        MEM_RegWr,
  output logic        MEM_MemtoReg,
  output logic        MEM_AlignErr,
  output logic [4:0]  WB_Rw,
  output logic        WB_RegWr,
  output logic [31:0] WB_BusW
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              mem_memwr;
  logic [31:0]       mem_b;
  logic [31:0]       dmem [DEPTH];
  logic [ADDR_W-1:0] mem_idx;
  logic [31:0]       rd_data;
  logic              mem_we;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      MEM_Result   <= '0;
      mem_b        <= '0;
      MEM_Rw       <= '0;
      MEM_RegWr    <= 1'b0;
      mem_memwr    <= 1'b0;
      MEM_MemtoReg <= 1'b0;
    end else if (stall) begin
      MEM_Result   <= '0;
      mem_b        <= '0;
      MEM_Rw       <= '0;
      MEM_RegWr    <= 1'b0;
      mem_memwr    <= 1'b0;
      MEM_MemtoReg <= 1'b0;
    end else begin
      MEM_Result   <= EXE_Result;
      mem_b        <= EXE_B;
      MEM_Rw       <= EXE_Rw;
      // $0 is hardwired: never forward it or write it
      MEM_RegWr    <= EXE_RegWr & (EXE_Rw != 5'd0);
      mem_memwr    <= EXE_MemWr;
      MEM_MemtoReg <= EXE_MemtoReg;
    end
  end

  assign mem_idx      = MEM_Result[ADDR_W+1:2];
  assign MEM_AlignErr = (mem_memwr | MEM_MemtoReg) & (MEM_Result[1:0] != 2'b00);
  assign rd_data      = MEM_AlignErr ? 32'd0 : dmem[mem_idx];
  // A store caught in MEM by reset is dropped along with the rest of the pipeline
  assign mem_we       = mem_memwr & ~MEM_AlignErr & ~Reset;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      dmem[mem_idx] <= mem_b;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      WB_Rw    <= '0;
      WB_RegWr <= 1'b0;
      WB_BusW  <= '0;
    end else begin
      WB_Rw    <= MEM_Rw;
      WB_RegWr <= MEM_RegWr;
      WB_BusW  <= MEM_MemtoReg ? rd_data : MEM_Result;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expectations from a reference memory model,
// queued at issue and compared when the instruction reaches MEM and WB.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] EXE_Result, EXE_B;
  logic [4:0]  EXE_Rw;
  logic        EXE_RegWr, EXE_MemWr, EXE_MemtoReg, stall;
  logic [31:0] MEM_Result, WB_BusW;
  logic [4:0]  MEM_Rw, WB_Rw;
  logic        MEM_RegWr, MEM_MemtoReg, MEM_AlignErr, WB_RegWr;

  mem_wb_stage #(.ADDR_W(10)) dut (
    .Clk(Clk), .Reset(Reset),
    .EXE_Result(EXE_Result), .EXE_B(EXE_B), .EXE_Rw(EXE_Rw),
    .EXE_RegWr(EXE_RegWr), .EXE_MemWr(EXE_MemWr), .EXE_MemtoReg(EXE_MemtoReg),
    .stall(stall),
    .MEM_Result(MEM_Result), .MEM_Rw(MEM_Rw), .MEM_RegWr(MEM_RegWr),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_AlignErr(MEM_AlignErr),
    .WB_Rw(WB_Rw), .WB_RegWr(WB_RegWr), .WB_BusW(WB_BusW)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] res, b;
    logic [4:0]  rw;
    logic        regwr, memwr, mtr, stl;
  } stim_t;

  typedef struct {
    logic [31:0] result, bus;
    logic [4:0]  rw;
    logic        regwr, mtr, aerr;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] ref_mem [int];

  function automatic stim_t mk(logic [31:0] res, logic [31:0] b, logic [4:0] rw,
                               logic regwr, logic memwr, logic mtr, logic stl);
    stim_t s;
    s.res = res; s.b = b; s.rw = rw; s.regwr = regwr;
    s.memwr = memwr; s.mtr = mtr; s.stl = stl;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Reference behaviour of one instruction; updates the memory model in program order.
  function automatic exp_t model(stim_t s);
    exp_t e;
    int   idx;
    if (s.stl) begin
      s.res = 0; s.b = 0; s.rw = 0; s.regwr = 0; s.memwr = 0; s.mtr = 0;
    end
    e.result = s.res;
    e.rw     = s.rw;
    e.regwr  = s.regwr && (s.rw != 5'd0);
    e.mtr    = s.mtr;
    e.aerr   = (s.memwr || s.mtr) && (s.res[1:0] != 2'b00);
    idx      = int'(s.res[11:2]);
    if (!s.mtr)      e.bus = s.res;
    else if (e.aerr) e.bus = 32'd0;
    else             e.bus = ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;
    if (s.memwr && !e.aerr) ref_mem[idx] = s.b;
    return e;
  endfunction

  task automatic drive(stim_t s);
    EXE_Result = s.res; EXE_B = s.b; EXE_Rw = s.rw; EXE_RegWr = s.regwr;
    EXE_MemWr = s.memwr; EXE_MemtoReg = s.mtr; stall = s.stl;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(idle());
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (MEM_Result !== 32'd0 || MEM_Rw !== 5'd0 || MEM_RegWr !== 1'b0 || MEM_MemtoReg !== 1'b0 ||
        MEM_AlignErr !== 1'b0 || WB_Rw !== 5'd0 || WB_RegWr !== 1'b0 || WB_BusW !== 32'd0) begin
      errors++;
      $display("FAIL reset_held: mem res=%h rw=%0d rwe=%b mtr=%b aerr=%b wb rw=%0d rwe=%b bus=%h, all required 0",
               MEM_Result, MEM_Rw, MEM_RegWr, MEM_MemtoReg, MEM_AlignErr, WB_Rw, WB_RegWr, WB_BusW);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (MEM_Result !== 32'd0 || MEM_Rw !== 5'd0 || MEM_RegWr !== 1'b0 || MEM_AlignErr !== 1'b0 ||
        WB_Rw !== 5'd0 || WB_RegWr !== 1'b0 || WB_BusW !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: mem res=%h rw=%0d rwe=%b aerr=%b wb rw=%0d rwe=%b bus=%h, all required 0",
               MEM_Result, MEM_Rw, MEM_RegWr, MEM_AlignErr, WB_Rw, WB_RegWr, WB_BusW);
    end
  endtask

  task automatic test_alu_store_load();
    stim_t prog[$];
    exp_t  e;
    prog.push_back(mk(32'h55, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0));
    prog.push_back(mk(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(32'h10, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0));
    prog.push_back(mk(32'h20, 32'h5555_0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(32'h20, 32'h0000_0077, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0));
    prog.push_back(mk(32'h20, 32'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0));
    prog.push_back(idle());
    prog.push_back(idle());
    foreach (prog[i]) begin
      @(negedge Clk);
      if (sb.size() >= 1) begin
        e = sb[$];
        checks++;
        if (MEM_Result !== e.result || MEM_Rw !== e.rw || MEM_RegWr !== e.regwr ||
            MEM_MemtoReg !== e.mtr || MEM_AlignErr !== e.aerr) begin
          errors++;
          $display("FAIL alu_mem_stage[%0d]: got res=%h rw=%0d rwe=%b mtr=%b aerr=%b, want res=%h rw=%0d rwe=%b mtr=%b aerr=%b",
                   i, MEM_Result, MEM_Rw, MEM_RegWr, MEM_MemtoReg, MEM_AlignErr,
                   e.result, e.rw, e.regwr, e.mtr, e.aerr);
        end
      end
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        checks++;
        if (WB_Rw !== e.rw || WB_RegWr !== e.regwr || WB_BusW !== e.bus) begin
          errors++;
          $display("FAIL alu_wb_stage[%0d]: got rw=%0d rwe=%b bus=%h, want rw=%0d rwe=%b bus=%h",
                   i, WB_Rw, WB_RegWr, WB_BusW, e.rw, e.regwr, e.bus);
        end
      end
      drive(prog[i]);
      sb.push_back(model(prog[i]));
    end
  endtask

  task automatic test_stall_align();
    stim_t prog[$];
    exp_t  e;
    prog.push_back(mk(32'h44, 32'h99, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1));
    prog.push_back(mk(32'h13, 32'h1234, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(32'h10, 32'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0));
    prog.push_back(mk(32'h22, 32'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0));
    prog.push_back(mk(32'h7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    prog.push_back(idle());
    prog.push_back(idle());
    foreach (prog[i]) begin
      @(negedge Clk);
      if (sb.size() >= 1) begin
        e = sb[$];
        checks++;
        if (MEM_Result !== e.result || MEM_Rw !== e.rw || MEM_RegWr !== e.regwr ||
            MEM_MemtoReg !== e.mtr || MEM_AlignErr !== e.aerr) begin
          errors++;
          $display("FAIL stall_align_mem[%0d]: got res=%h rw=%0d rwe=%b mtr=%b aerr=%b, want res=%h rw=%0d rwe=%b mtr=%b aerr=%b",
                   i, MEM_Result, MEM_Rw, MEM_RegWr, MEM_MemtoReg, MEM_AlignErr,
                   e.result, e.rw, e.regwr, e.mtr, e.aerr);
        end
      end
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        checks++;
        if (WB_Rw !== e.rw || WB_RegWr !== e.regwr || WB_BusW !== e.bus) begin
          errors++;
          $display("FAIL stall_align_wb[%0d]: got rw=%0d rwe=%b bus=%h, want rw=%0d rwe=%b bus=%h",
                   i, WB_Rw, WB_RegWr, WB_BusW, e.rw, e.regwr, e.bus);
        end
      end
      drive(prog[i]);
      sb.push_back(model(prog[i]));
    end
  endtask

  task automatic test_rw0_alias();
    stim_t prog[$];
    exp_t  e;
    prog.push_back(mk(32'h66, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    prog.push_back(mk(32'h1000_0004, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(32'h4, 32'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0));
    prog.push_back(mk(32'h4, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    prog.push_back(mk(32'h40, 32'h0000_AAAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(idle());
    prog.push_back(idle());
    foreach (prog[i]) begin
      @(negedge Clk);
      if (sb.size() >= 1) begin
        e = sb[$];
        checks++;
        if (MEM_Result !== e.result || MEM_Rw !== e.rw || MEM_RegWr !== e.regwr ||
            MEM_MemtoReg !== e.mtr || MEM_AlignErr !== e.aerr) begin
          errors++;
          $display("FAIL rw0_alias_mem[%0d]: got res=%h rw=%0d rwe=%b mtr=%b aerr=%b, want res=%h rw=%0d rwe=%b mtr=%b aerr=%b",
                   i, MEM_Result, MEM_Rw, MEM_RegWr, MEM_MemtoReg, MEM_AlignErr,
                   e.result, e.rw, e.regwr, e.mtr, e.aerr);
        end
      end
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        checks++;
        if (WB_Rw !== e.rw || WB_RegWr !== e.regwr || WB_BusW !== e.bus) begin
          errors++;
          $display("FAIL rw0_alias_wb[%0d]: got rw=%0d rwe=%b bus=%h, want rw=%0d rwe=%b bus=%h",
                   i, WB_Rw, WB_RegWr, WB_BusW, e.rw, e.regwr, e.bus);
        end
      end
      drive(prog[i]);
      sb.push_back(model(prog[i]));
    end
  endtask

  task automatic test_reset_midstream();
    stim_t prog[$];
    exp_t  e;
    // Store to 0x40 is issued, then reset hits while it sits in MEM; the model never sees it.
    @(negedge Clk);
    drive(mk(32'h40, 32'h0000_BBBB, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(negedge Clk);
    Reset = 1'b1;
    drive(idle());
    @(negedge Clk);
    checks++;
    if (MEM_Result !== 32'd0 || MEM_RegWr !== 1'b0 || MEM_AlignErr !== 1'b0 ||
        WB_RegWr !== 1'b0 || WB_BusW !== 32'd0) begin
      errors++;
      $display("FAIL reset_midstream_flush: mem res=%h rwe=%b aerr=%b wb rwe=%b bus=%h, all required 0",
               MEM_Result, MEM_RegWr, MEM_AlignErr, WB_RegWr, WB_BusW);
    end
    @(negedge Clk);
    Reset = 1'b0;
    sb.delete();
    prog.push_back(mk(32'h40, 32'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0));
    prog.push_back(idle());
    prog.push_back(idle());
    foreach (prog[i]) begin
      if (i != 0) @(negedge Clk);
      if (sb.size() >= 1) begin
        e = sb[$];
        checks++;
        if (MEM_Result !== e.result || MEM_Rw !== e.rw || MEM_RegWr !== e.regwr ||
            MEM_MemtoReg !== e.mtr || MEM_AlignErr !== e.aerr) begin
          errors++;
          $display("FAIL reset_mid_mem[%0d]: got res=%h rw=%0d rwe=%b mtr=%b aerr=%b, want res=%h rw=%0d rwe=%b mtr=%b aerr=%b",
                   i, MEM_Result, MEM_Rw, MEM_RegWr, MEM_MemtoReg, MEM_AlignErr,
                   e.result, e.rw, e.regwr, e.mtr, e.aerr);
        end
      end
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        checks++;
        if (WB_Rw !== e.rw || WB_RegWr !== e.regwr || WB_BusW !== e.bus) begin
          errors++;
          $display("FAIL reset_mid_wb[%0d]: got rw=%0d rwe=%b bus=%h, want rw=%0d rwe=%b bus=%h",
                   i, WB_Rw, WB_RegWr, WB_BusW, e.rw, e.regwr, e.bus);
        end
      end
      drive(prog[i]);
      sb.push_back(model(prog[i]));
    end
  endtask

  initial begin
    test_reset();
    test_alu_store_load();
    test_stall_align();
    test_rw0_alias();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
